// File: rtl/ctrl_tx.sv
// Serial frame transmitter paced by an external baud generator.
// Start bit, NB data bits LSB first, optional parity, NSTOP stop bits.
module ctrl_tx #(
    parameter int NB    = 8,
    parameter int PAR   = 0,
    parameter int NSTOP = 1,
    parameter int TMO   = 1024
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          start,
    input  logic [NB-1:0] dato,
    input  logic          ckd,
    output logic          f,
    output logic          tx,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int BW = $clog2(NB + 1);
    localparam int SW = $clog2(NSTOP + 1);
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARRANQUE,
        DATOS,
        PARIDAD,
        PARO,
        FIN
    } state_t;

    state_t          r_state;
    logic [NB-1:0]   r_sh;
    logic            r_par;
    logic [BW-1:0]   r_nbit;
    logic [SW-1:0]   r_nstop;
    logic [CW-1:0]   r_cnt;
    logic            r_s1;
    logic            r_s2;
    logic            r_s3;
    logic            w_tick;

    // r_s3 only remembers the previous synchronized level for edge detection
    assign w_tick = r_s2 & ~r_s3;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= ckd;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_par   <= 1'b0;
            r_nbit  <= '0;
            r_nstop <= '0;
            r_cnt   <= '0;
            f       <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == IDLE) begin
                f    <= 1'b0;
                tx   <= 1'b1;
                busy <= 1'b0;
                if (start) begin
                    r_sh    <= dato;
                    r_par   <= ^dato;
                    r_nbit  <= '0;
                    r_nstop <= '0;
                    r_cnt   <= '0;
                    f       <= 1'b1;
                    tx      <= 1'b0;
                    busy    <= 1'b1;
                    r_state <= ARRANQUE;
                end
            end else if (!w_tick && r_cnt == CW'(TMO - 1)) begin
                // generator stalled: abandon the frame without a done pulse
                r_state <= IDLE;
                r_cnt   <= '0;
                f       <= 1'b0;
                tx      <= 1'b1;
                busy    <= 1'b0;
                err     <= 1'b1;
            end else begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                case (r_state)
                    ARRANQUE: begin
                        if (w_tick) begin
                            tx      <= r_sh[0];
                            r_state <= DATOS;
                        end
                    end
                    DATOS: begin
                        if (w_tick) begin
                            r_sh   <= r_sh >> 1;
                            r_nbit <= r_nbit + 1'b1;
                            if (r_nbit == BW'(NB - 1)) begin
                                if (PAR != 0) begin
                                    tx      <= (PAR == 2) ? ~r_par : r_par;
                                    r_state <= PARIDAD;
                                end else begin
                                    tx      <= 1'b1;
                                    r_state <= PARO;
                                end
                            end else begin
                                tx <= r_sh[1];
                            end
                        end
                    end
                    PARIDAD: begin
                        if (w_tick) begin
                            tx      <= 1'b1;
                            r_state <= PARO;
                        end
                    end
                    PARO: begin
                        tx <= 1'b1;
                        if (w_tick) begin
                            if (r_nstop == SW'(NSTOP - 1)) begin
                                f       <= 1'b0;
                                done    <= 1'b1;
                                r_state <= FIN;
                            end else begin
                                r_nstop <= r_nstop + 1'b1;
                            end
                        end
                    end
                    FIN: begin
                        f       <= 1'b0;
                        tx      <= 1'b1;
                        busy    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ctrl_tx.md
CTRL_TX -- requirements
Module: ctrl_tx

Interface
REQ-001 SHALL have parameter NB, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter PAR, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter NSTOP, default 1, number of stop bits (1 or 2).
REQ-004 SHALL have parameter TMO, default 1024, clock cycles allowed between baud ticks before abort.
REQ-005 SHALL have port ck, input, 1, single system clock; all state updates occur on rising edge of ck.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-007 SHALL have port start, input, 1, request to transmit dato.
REQ-008 SHALL have port dato, input, NB, byte to transmit, sampled when start is accepted.
REQ-009 SHALL have port ckd, input, 1, divided clock returned by the baud generator; asynchronous to ck phase.
REQ-010 SHALL have port f, output, 1, enable to the baud generator (generator holds ckd=1 while f=0).
REQ-011 SHALL have port tx, output, 1, serial line, idle high.
REQ-012 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at frame end.
REQ-014 SHALL have port err, output, 1, sticky timeout flag.

Function
REQ-015 SHALL pass ckd through a two-flop synchronizer; a baud tick is one ck cycle where synchronized ckd goes 0->1.
REQ-016 SHALL implement states IDLE, ARRANQUE, DATOS, PARIDAD, PARO, FIN.
REQ-017 IDLE: f=0, tx=1, busy=0; start=1 SHALL latch dato into shift register and move to ARRANQUE next cycle.
REQ-018 ARRANQUE: f=1, tx=0, busy=1 from the first cycle after start acceptance; move to DATOS on tick.
REQ-019 DATOS: tx = shift register bit 0 (LSB first); on each tick shift right, bit counter +1; after NB ticks go to PARIDAD if PAR!=0, else PARO.
REQ-020 PARIDAD: tx = XOR of latched bits (PAR=1) or its inverse (PAR=2); move to PARO on tick.
REQ-021 PARO: tx=1; leave after NSTOP ticks to FIN.
REQ-022 FIN: f=0, tx=1, done=1 for exactly one cycle, busy=1; then IDLE unconditionally.
REQ-023 start SHALL be ignored in every state except IDLE; dato changes after acceptance SHALL not affect the frame.
REQ-024 A cycle counter SHALL clear on every tick and on entering ARRANQUE; if it reaches TMO in any busy state, go to IDLE, f=0, tx=1, err=1, no done pulse.
REQ-025 err SHALL remain 1 until rst; err=1 SHALL not block new frames.
REQ-026 Bit counter SHALL be wide enough for NB without wrap; counter never exceeds NB.
REQ-027 f SHALL drop to 0 for at least one cycle between consecutive frames, so the generator restarts its phase per frame.
REQ-028 start and tick in same cycle in IDLE: tick SHALL be ignored (f was 0).

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, f=0, tx=1, busy=0, done=0, err=0, counters and shift register to 0, synchronizer flops to 1.
REQ-030 rst asserted mid-frame SHALL abort the frame with tx=1 in the same cycle and no done pulse after release.
REQ-031 After rst release first start SHALL be accepted normally.

Verification
REQ-032 Generator model toggling ckd every 5 ck cycles (10-cycle bit), NB=8, PAR=0: start with dato=8'h55 -> tx sequence 0,1,0,1,0,1,0,1,0,1 then 1, each bit 10 cycles, done pulse once, busy low after.
REQ-033 PAR=1, dato=8'h07 -> parity bit 1; PAR=2, dato=8'h07 -> parity bit 0.
REQ-034 NSTOP=2, dato=8'hFF -> two stop bit periods (20 cycles high) before done.
REQ-035 start pulsed again during DATOS with dato=8'hAA -> ignored; transmitted frame stays first byte; no second done.
REQ-036 ckd held constant after ARRANQUE, TMO=64 -> after 64 cycles err=1, f=0, tx=1, busy=0, no done.
REQ-037 rst pulsed during bit 3 of DATOS -> tx=1, f=0 same cycle; next start with dato=8'h01 transmits full correct frame.
